// File: rtl/fir_pkg.sv
// Shared encodings for the FIR configuration controller: command codes,
// the error acknowledge byte and the frame FSM state enumeration.
package fir_pkg;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_WCOEF = 2'b01;
    localparam logic [1:0] CMD_WDIV  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    localparam logic [7:0] ACK_ERR = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_WRITE,
        ST_CLEAR,
        ST_ACK
    } state_t;

endpackage

// File: rtl/fir_rate_div.sv
// Sample-rate divider: holds the divider value and a free-running counter
// that wraps at the divider value, producing a one-cycle sample_en strobe.
// A divider write restarts the count so the first new strobe lands
// div_new+1 cycles after the write cycle.
module fir_rate_div
    import fir_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int DIV_RST = 0
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             div_we,
    input  logic [DIV_W-1:0] div_data,
    output logic             sample_en
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             se_q;

    // Next divider value and counter: wrap at div, restart on a divider write.
    always_comb begin
        div_d = div_q;
        cnt_d = (cnt_q == div_q) ? '0 : cnt_q + 1'b1;
        if (div_we) begin
            div_d = div_data;
            cnt_d = '0;
        end
    end

    // Strobe is registered from the next-state compare so it lines up with
    // the counter value it represents.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            div_q <= DIV_W'(DIV_RST);
            cnt_q <= '0;
            se_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
            se_q  <= (cnt_d == div_d);
        end
    end

    assign sample_en = se_q;

endmodule

// File: rtl/fir_cfg_ctrl.sv
// UART-side configuration controller for the FIR datapath. Parses header +
// payload frames from the receive byte stream, writes coefficient registers
// or the sample divider, sweeps the coefficient bank on CLEAR, and returns
// one acknowledge byte per frame.
module fir_cfg_ctrl
    import fir_pkg::*;
#(
    parameter int NTAPS   = 16,
    parameter int DW      = 32,
    parameter int DIV_W   = 16,
    parameter int DIV_RST = 0,
    parameter int TIMEOUT = 50000
) (
    input  logic                     clk,
    input  logic                     nRst,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic                     ack_valid,
    output logic [7:0]               ack_data,
    input  logic                     ack_ready,
    output logic                     coef_we,
    output logic [$clog2(NTAPS)-1:0] coef_addr,
    output logic [DW-1:0]            coef_data,
    output logic                     sample_en,
    output logic                     busy,
    output logic                     err
);

    localparam int AW = $clog2(NTAPS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(NTAPS + 1);

    state_t           state_q;
    logic [7:0]       hdr_q;
    logic [23:0]      shift_q;
    logic [1:0]       bcnt_q;
    logic [TW-1:0]    tcnt_q;
    logic [CW-1:0]    clr_q;
    logic             bad_q;
    logic             coef_we_q;
    logic [AW-1:0]    coef_addr_q;
    logic [DW-1:0]    coef_data_q;
    logic             div_we_q;
    logic [DIV_W-1:0] div_data_q;
    logic             ack_valid_q;
    logic [7:0]       ack_data_q;
    logic             err_q;

    logic [31:0]      word_w;
    logic             addr_ok_w;

    // Full payload word as it stands once the current byte is shifted in.
    assign word_w    = {shift_q, rx_data};
    assign addr_ok_w = ({1'b0, hdr_q[5:0]} < 7'(NTAPS));

    // Frame FSM with registered strobes and acknowledge outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= ST_IDLE;
            hdr_q       <= '0;
            shift_q     <= '0;
            bcnt_q      <= '0;
            tcnt_q      <= '0;
            clr_q       <= '0;
            bad_q       <= 1'b0;
            coef_we_q   <= 1'b0;
            coef_addr_q <= '0;
            coef_data_q <= '0;
            div_we_q    <= 1'b0;
            div_data_q  <= '0;
            ack_valid_q <= 1'b0;
            ack_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            coef_we_q <= 1'b0;
            div_we_q  <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid) begin
                        hdr_q <= rx_data;
                        case (rx_data[7:6])
                            CMD_NOP: begin
                                ack_valid_q <= 1'b1;
                                ack_data_q  <= rx_data;
                                state_q     <= ST_ACK;
                            end
                            CMD_CLEAR: begin
                                coef_we_q   <= 1'b1;
                                coef_addr_q <= '0;
                                coef_data_q <= '0;
                                clr_q       <= CW'(1);
                                state_q     <= ST_CLEAR;
                            end
                            default: begin
                                bcnt_q  <= '0;
                                tcnt_q  <= '0;
                                state_q <= ST_DATA;
                            end
                        endcase
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        shift_q <= word_w[23:0];
                        tcnt_q  <= '0;
                        bcnt_q  <= bcnt_q + 1'b1;
                        if (bcnt_q == 2'd3) begin
                            state_q <= ST_WRITE;
                            bad_q   <= 1'b0;
                            if (hdr_q[7:6] == CMD_WCOEF) begin
                                if (addr_ok_w) begin
                                    coef_we_q   <= 1'b1;
                                    coef_addr_q <= hdr_q[AW-1:0];
                                    coef_data_q <= word_w;
                                end else begin
                                    bad_q <= 1'b1;
                                end
                            end else begin
                                div_we_q   <= 1'b1;
                                div_data_q <= word_w[DIV_W-1:0];
                            end
                        end
                    end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        // Stalled frame: drop the partial word, no acknowledge.
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                ST_WRITE: begin
                    err_q       <= bad_q | rx_valid;
                    ack_valid_q <= 1'b1;
                    ack_data_q  <= bad_q ? ACK_ERR : hdr_q;
                    state_q     <= ST_ACK;
                end
                ST_CLEAR: begin
                    err_q <= rx_valid;
                    if (clr_q == CW'(NTAPS)) begin
                        ack_valid_q <= 1'b1;
                        ack_data_q  <= hdr_q;
                        state_q     <= ST_ACK;
                    end else begin
                        coef_we_q   <= 1'b1;
                        coef_addr_q <= clr_q[AW-1:0];
                        coef_data_q <= '0;
                        clr_q       <= clr_q + 1'b1;
                    end
                end
                ST_ACK: begin
                    err_q <= rx_valid;
                    if (ack_ready) begin
                        ack_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    fir_rate_div #(
        .DIV_W   (DIV_W),
        .DIV_RST (DIV_RST)
    ) u_rate_div (
        .clk       (clk),
        .nRst      (nRst),
        .div_we    (div_we_q),
        .div_data  (div_data_q),
        .sample_en (sample_en)
    );

    assign ack_valid = ack_valid_q;
    assign ack_data  = ack_data_q;
    assign coef_we   = coef_we_q;
    assign coef_addr = coef_addr_q;
    assign coef_data = coef_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// Bench for fir_cfg_ctrl: expected coefficient writes and acknowledge bytes
// are queued as frames are sent and compared as the DUT produces them.
module tb_fir_cfg_ctrl;

    localparam int NTAPS   = 16;
    localparam int DW      = 32;
    localparam int DIV_W   = 16;
    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        ack_ready = 1'b0;
    logic        ack_valid;
    logic [7:0]  ack_data;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [31:0] coef_data;
    logic        sample_en;
    logic        busy;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt = 0;
    int we_cnt  = 0;
    int ackv_cnt = 0;
    int se_cnt  = 0;

    logic [3:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [7:0]  exp_ack_q[$];

    fir_cfg_ctrl #(
        .NTAPS   (NTAPS),
        .DW      (DW),
        .DIV_W   (DIV_W),
        .DIV_RST (0),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .ack_valid (ack_valid),
        .ack_data  (ack_data),
        .ack_ready (ack_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .sample_en (sample_en),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard side: compare writes and acknowledge handshakes on the falling edge.
    always @(negedge clk) begin
        if (nRst) begin
            if (coef_we) begin
                we_cnt++;
                if (exp_addr_q.size() == 0) begin
                    chk("coef_we_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("coef_addr", 32'(coef_addr), 32'(exp_addr_q.pop_front()));
                    chk("coef_data", coef_data, exp_data_q.pop_front());
                end
            end
            if (ack_valid) ackv_cnt++;
            if (err) err_cnt++;
            if (sample_en) se_cnt++;
            if (ack_valid && ack_ready) begin
                if (exp_ack_q.size() == 0)
                    chk("ack_unexpected", 32'd1, 32'd0);
                else
                    chk("ack_byte", 32'(ack_data), 32'(exp_ack_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [3:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    task automatic wait_ack();
        int t;
        t = 0;
        while (!ack_valid && t < 200) begin
            tick();
            t++;
        end
        if (!ack_valid) begin
            chk("ack_timeout", 32'd0, 32'd1);
        end else begin
            tick(2);
            chk("ack_hold_valid", 32'(ack_valid), 32'd1);
            if (exp_ack_q.size() == 0)
                chk("ack_queue_empty", 32'd1, 32'd0);
            else
                chk("ack_hold_data", 32'(ack_data), 32'(exp_ack_q[0]));
            ack_ready = 1'b1;
            tick();
            ack_ready = 1'b0;
            #3;
            chk("post_ack_busy", 32'(busy), 32'd0);
            chk("post_ack_valid", 32'(ack_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int run;
        int w0;
        int a0;

        // Reset values
        #12;
        chk("rst_sample_en", 32'(sample_en), 32'd0);
        chk("rst_ack_valid", 32'(ack_valid), 32'd0);
        chk("rst_coef_we", 32'(coef_we), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_coef_data", coef_data, 32'd0);
        @(posedge clk);
        #1;
        nRst = 1'b1;
        tick();
        se_cnt = 0; err_cnt = 0; we_cnt = 0; ackv_cnt = 0;
        tick(20);
        chk("idle_se_every_cycle", 32'(se_cnt), 32'd20);
        chk("idle_err", 32'(err_cnt), 32'd0);
        chk("idle_we", 32'(we_cnt), 32'd0);
        chk("idle_ack", 32'(ackv_cnt), 32'd0);

        // WCOEF addr 3
        err_cnt = 0;
        push_wr(4'd3, 32'h0000_0131);
        exp_ack_q.push_back(8'h43);
        send(8'h43);
        chk("hdr_busy", 32'(busy), 32'd1);
        send(8'h00); send(8'h00); send(8'h01); send(8'h31);
        #3;
        chk("wcoef_we_n1", 32'(coef_we), 32'd1);
        tick();
        #3;
        chk("wcoef_we_single", 32'(coef_we), 32'd0);
        chk("wcoef_ack_n2", 32'(ack_valid), 32'd1);
        wait_ack();
        chk("wcoef_err", 32'(err_cnt), 32'd0);

        // WDIV = 7
        exp_ack_q.push_back(8'h80);
        send(8'h80); send(8'h00); send(8'h00); send(8'h00); send(8'h07);
        tick();
        d = -1;
        for (int i = 0; i < 40; i++) begin
            #3;
            if (sample_en) begin
                d = i;
                break;
            end
            tick();
        end
        chk("div_first_pulse", 32'(d + 1), 32'd8);
        tick();
        se_cnt = 0;
        tick(32);
        chk("div_period", 32'(se_cnt), 32'd4);
        wait_ack();

        // WCOEF with out-of-range address
        err_cnt = 0;
        w0 = we_cnt;
        exp_ack_q.push_back(8'hEE);
        send(8'h7F); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        wait_ack();
        chk("badaddr_err", 32'(err_cnt), 32'd1);
        chk("badaddr_nowe", 32'(we_cnt), 32'(w0));

        // CLEAR sweep with a stray byte in the middle
        err_cnt = 0;
        for (int i = 0; i < NTAPS; i++) push_wr(4'(i), 32'd0);
        exp_ack_q.push_back(8'hC0);
        send(8'hC0);
        run = 0;
        for (int i = 0; i < NTAPS; i++) begin
            if (i == 5) begin
                rx_valid = 1'b1;
                rx_data  = 8'h55;
            end else begin
                rx_valid = 1'b0;
            end
            #3;
            if (coef_we) run++;
            tick();
        end
        rx_valid = 1'b0;
        #3;
        chk("clear_run", 32'(run), 32'(NTAPS));
        chk("clear_we_done", 32'(coef_we), 32'd0);
        chk("clear_ack_next", 32'(ack_valid), 32'd1);
        wait_ack();
        chk("clear_stray_err", 32'(err_cnt), 32'd1);

        // Timeout mid-frame, then a clean frame
        err_cnt = 0;
        w0 = we_cnt;
        a0 = ackv_cnt;
        send(8'h41); send(8'h11); send(8'h22);
        tick(TIMEOUT + 10);
        chk("timeout_err", 32'(err_cnt), 32'd1);
        chk("timeout_idle", 32'(busy), 32'd0);
        chk("timeout_noack", 32'(ackv_cnt), 32'(a0));
        chk("timeout_nowe", 32'(we_cnt), 32'(w0));
        push_wr(4'd5, 32'hDEAD_BEEF);
        exp_ack_q.push_back(8'h45);
        send(8'h45); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        wait_ack();

        // Reset mid-frame discards the partial frame
        w0 = we_cnt;
        send(8'h46); send(8'h12); send(8'h34);
        nRst = 1'b0;
        tick(2);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_addr", 32'(coef_addr), 32'd0);
        nRst = 1'b1;
        tick(10);
        chk("midrst_nowe", 32'(we_cnt), 32'(w0));
        chk("midrst_noack", 32'(ack_valid), 32'd0);
        push_wr(4'd6, 32'h0000_0009);
        exp_ack_q.push_back(8'h46);
        send(8'h46); send(8'h00); send(8'h00); send(8'h00); send(8'h09);
        wait_ack();

        tick(3);
        chk("coef_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        chk("ack_queue_drained", 32'(exp_ack_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
